// File: rtl/icache_refill_writer.sv
// icache_refill_writer
//
// Takes whole refill lines from the response deserializer and matches
// them, in order, against a queue of pending misses. An accepted line is
// written into the victim way one word per cycle, starting at the critical
// word. The tag (with its valid bit) is written last. The critical word goes
// back to the fetch unit one cycle after acceptance.
//
// Optional feature: define ICACHE_REFILL_ID_CHECK_EN to compare each
// response ID with the queue-head ID. A mismatch takes the error path and
// sets the sticky id_mismatch_o flag. When the macro is undefined,
// id_mismatch_o is tied to 0.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   miss_*                    miss push interface from the cache controller
//   refill_*                  whole-line refill response (valid/ready)
//   data_*                    SCM data bank write port
//   tag_*                     tag bank write port, wdata = {valid, tag}
//   fetch_*                   critical-word return to the fetch unit
//   busy_o                    a line is being written or dropped
//   id_mismatch_o             sticky response-ID mismatch flag
module icache_refill_writer #(
    parameter int CACHE_LINE        = 4,
    parameter int ICACHE_DATA_WIDTH = 32,
    parameter int AXI_ID            = 6,
    parameter int AXI_USER          = 8,
    parameter int NB_WAYS           = 4,
    parameter int SET_ID_WIDTH      = 5,
    parameter int TAG_WIDTH         = 22,
    parameter int MISS_DEPTH        = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    miss_valid_i,
    output logic                                    miss_ready_o,
    input  logic [TAG_WIDTH-1:0]                    miss_tag_i,
    input  logic [SET_ID_WIDTH-1:0]                 miss_set_i,
    input  logic [$clog2(CACHE_LINE)-1:0]           miss_word_i,
    input  logic [$clog2(NB_WAYS)-1:0]              miss_way_i,
    input  logic [AXI_ID-1:0]                       miss_id_i,
    input  logic [AXI_ID-1:0]                       refill_rid_i,
    input  logic [CACHE_LINE*ICACHE_DATA_WIDTH-1:0] refill_rdata_i,
    input  logic [1:0]                              refill_rresp_i,
    input  logic [AXI_USER-1:0]                     refill_ruser_i,
    input  logic                                    refill_rvalid_i,
    output logic                                    refill_rready_o,
    output logic                                    data_we_o,
    output logic [$clog2(NB_WAYS)-1:0]              data_way_o,
    output logic [SET_ID_WIDTH-1:0]                 data_set_o,
    output logic [$clog2(CACHE_LINE)-1:0]           data_word_o,
    output logic [ICACHE_DATA_WIDTH-1:0]            data_wdata_o,
    output logic                                    tag_we_o,
    output logic [$clog2(NB_WAYS)-1:0]              tag_way_o,
    output logic [SET_ID_WIDTH-1:0]                 tag_set_o,
    output logic [TAG_WIDTH:0]                      tag_wdata_o,
    output logic                                    fetch_rvalid_o,
    output logic [ICACHE_DATA_WIDTH-1:0]            fetch_rdata_o,
    output logic                                    fetch_err_o,
    output logic                                    busy_o,
    output logic                                    id_mismatch_o
);

    localparam int WORD_W = $clog2(CACHE_LINE);
    localparam int WAY_W  = $clog2(NB_WAYS);
    localparam int PTR_W  = $clog2(MISS_DEPTH);
    localparam int LINE_W = CACHE_LINE * ICACHE_DATA_WIDTH;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]    tag;
        logic [SET_ID_WIDTH-1:0] set;
        logic [WORD_W-1:0]       word;
        logic [WAY_W-1:0]        way;
        logic [AXI_ID-1:0]       id;
    } miss_t;

    typedef enum logic [1:0] {IDLE, WRITE_DATA, WRITE_TAG, ERROR} state_t;

    // ---------------- pending-miss queue ----------------
    miss_t            queue_q [MISS_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full, empty, push, accept;
    miss_t            head;

    state_t state_q, state_d;

    assign full            = (count_q == (PTR_W+1)'(MISS_DEPTH));
    assign empty           = (count_q == '0);
    assign miss_ready_o    = !full;
    assign refill_rready_o = (state_q == IDLE) && !empty;
    // A push is decided on registered fullness, so a pop in the same cycle
    // does not make room for it.
    assign push            = miss_valid_i && !full;
    assign accept          = refill_rvalid_i && refill_rready_o;
    assign head            = queue_q[rd_ptr_q];

    // NOTE: the queue storage has no reset; the pointers and count define which
    // entries are live, so stale contents are never observed after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_q[wr_ptr_q] <= '{tag: miss_tag_i, set: miss_set_i, word: miss_word_i,
                                   way: miss_way_i, id: miss_id_i};
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (accept) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, accept})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- acceptance decision ----------------
    logic                         id_bad, accept_err;
    logic [ICACHE_DATA_WIDTH-1:0] crit_word;
    logic                         unused_ok;

`ifdef ICACHE_REFILL_ID_CHECK_EN
    assign id_bad    = (refill_rid_i != head.id);
    assign unused_ok = ^{refill_ruser_i, refill_rresp_i[0]};
`else
    assign id_bad    = 1'b0;
    assign unused_ok = ^{refill_ruser_i, refill_rresp_i[0], refill_rid_i, head.id};
`endif

    assign accept_err = refill_rresp_i[1] | id_bad;
    assign crit_word  = refill_rdata_i[head.word*ICACHE_DATA_WIDTH +: ICACHE_DATA_WIDTH];

    // ---------------- line buffer and fetch return ----------------
    logic [LINE_W-1:0]       line_q;
    logic [WORD_W-1:0]       crit_q, k_q, word_idx;
    logic [WAY_W-1:0]        way_q;
    logic [SET_ID_WIDTH-1:0] set_q;
    logic [TAG_WIDTH-1:0]    tag_q;

    // Line buffer and write counter are only read while busy, and they are
    // always loaded on acceptance, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_q <= refill_rdata_i;
            crit_q <= head.word;
            way_q  <= head.way;
            set_q  <= head.set;
            tag_q  <= head.tag;
            k_q    <= '0;
        end else if (state_q == WRITE_DATA) begin
            k_q <= k_q + WORD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            fetch_rvalid_o <= 1'b0;
            fetch_err_o    <= 1'b0;
            fetch_rdata_o  <= '0;
        end else begin
            state_q        <= state_d;
            fetch_rvalid_o <= accept;
            fetch_err_o    <= accept && accept_err;
            fetch_rdata_o  <= (accept && !accept_err) ? crit_word : '0;
        end
    end

`ifdef ICACHE_REFILL_ID_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  id_mismatch_o <= 1'b0;
        else if (accept && id_bad) id_mismatch_o <= 1'b1;
    end
`else
    assign id_mismatch_o = 1'b0;
`endif

    // Critical-word-first order wraps naturally in WORD_W bits.
    assign word_idx = crit_q + k_q;
    assign busy_o   = (state_q != IDLE);

    // NOTE: every output and next-state variable gets a default first, so
    // no path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        data_we_o    = 1'b0;
        data_way_o   = '0;
        data_set_o   = '0;
        data_word_o  = '0;
        data_wdata_o = '0;
        tag_we_o     = 1'b0;
        tag_way_o    = '0;
        tag_set_o    = '0;
        tag_wdata_o  = '0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = accept_err ? ERROR : WRITE_DATA;
            end
            WRITE_DATA: begin
                data_we_o    = 1'b1;
                data_way_o   = way_q;
                data_set_o   = set_q;
                data_word_o  = word_idx;
                data_wdata_o = line_q[word_idx*ICACHE_DATA_WIDTH +: ICACHE_DATA_WIDTH];
                if (k_q == WORD_W'(CACHE_LINE-1)) state_d = WRITE_TAG;
            end
            WRITE_TAG: begin
                tag_we_o    = 1'b1;
                tag_way_o   = way_q;
                tag_set_o   = set_q;
                tag_wdata_o = {1'b1, tag_q};
                state_d     = IDLE;
            end
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule
